dmem_responder: RTL



---
 rtl/dmem_responder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request channel, fixed access latency, held response.
// Optional performance counters are built when DMEM_PERF_EN is defined.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] perf_rd_cnt,
    output logic [15:0] perf_wr_cnt,
    output logic [15:0] perf_err_cnt
);

    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1      = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q;
    logic            reqReady_q;
    logic            rspValid_q;
    logic            rspErr_q;
    logic [31:0]     rspRdata_q;
    logic [3:0]      cnt_q;
    logic            we_q;
    logic            err_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      mask_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            maskLegal;
    logic            reqErr;
    logic            commit;
    logic            unusedAddr;

    assign unusedAddr = ^req_addr[1:0];

    // Stores may only touch single bytes, aligned halfwords or the full word.
    always_comb begin
        maskLegal = 1'b0;
        case (req_mask)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: maskLegal = 1'b1;
            default:                   maskLegal = 1'b0;
        endcase
    end

    assign reqErr = (req_addr[31:2] >= DEPTH_LIMIT) || (req_we && !maskLegal);
    assign commit = (state_q == WAIT) && (cnt_q == 4'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            reqReady_q <= 1'b1;
            rspValid_q <= 1'b0;
            rspRdata_q <= 32'd0;
            rspErr_q   <= 1'b0;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            mask_q     <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        idx_q      <= req_addr[AW+1:2];
                        wdata_q    <= req_wdata;
                        mask_q     <= req_mask;
                        err_q      <= reqErr;
                        cnt_q      <= LAT_M1;
                        reqReady_q <= 1'b0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rspValid_q <= 1'b1;
                        rspErr_q   <= err_q;
                        rspRdata_q <= (!we_q && !err_q) ? mem[idx_q] : 32'd0;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        rspRdata_q <= 32'd0;
                        rspErr_q   <= 1'b0;
                        reqReady_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gating on rst_n makes a reset during WAIT abandon the pending store.
    always_ff @(posedge clk) begin
        if (rst_n && commit && we_q && !err_q) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = reqReady_q;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;

`ifdef DMEM_PERF_EN
    logic [15:0] perfRd_q;
    logic [15:0] perfWr_q;
    logic [15:0] perfErr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perfRd_q  <= 16'd0;
            perfWr_q  <= 16'd0;
            perfErr_q <= 16'd0;
        end else if (state_q == RESP && rsp_ready) begin
            if (rspErr_q) begin
                perfErr_q <= perfErr_q + 16'd1;
            end else if (we_q) begin
                perfWr_q <= perfWr_q + 16'd1;
            end else begin
                perfRd_q <= perfRd_q + 16'd1;
            end
        end
    end

    assign perf_rd_cnt  = perfRd_q;
    assign perf_wr_cnt  = perfWr_q;
    assign perf_err_cnt = perfErr_q;
`else
    assign perf_rd_cnt  = 16'd0;
    assign perf_wr_cnt  = 16'd0;
    assign perf_err_cnt = 16'd0;
`endif

endmodule
